// File: rtl/ex_mdu.sv
// Iterative RV M-extension multiply/divide unit (with RV64 *W variants) beside the execute ALU.
// Shift-add multiplier and restoring divider retire one bit per cycle; divide special cases skip iteration.
module ex_mdu #(
  parameter int XLEN = 64,
  parameter int RD_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic [2:0]      op_i,
  input  logic            word_i,
  input  logic [XLEN-1:0] op1_i,
  input  logic [XLEN-1:0] op2_i,
  input  logic [RD_W-1:0] rd_addr_i,
  input  logic            flush_i,
  output logic            busy_o,
  output logic            hold_flag_o,
  output logic [XLEN-1:0] rd_wdata_o,
  output logic [RD_W-1:0] rd_waddr_o,
  output logic            reg_wen_o
);
  localparam int CW = $clog2(XLEN) + 1;
  localparam logic [2:0] OP_MUL = 3'b000;

  typedef enum logic [1:0] {IDLE, CALC, FIN, DONE} state_t;

  state_t            state;
  logic [CW-1:0]     count;
  logic [2:0]        op_q;
  logic              word_q;
  logic              neg_q;
  logic [RD_W-1:0]   rd_q;
  logic [2*XLEN-1:0] a_q;  // mul: multiplicand shifting left; div: low half is dividend becoming quotient
  logic [XLEN-1:0]   b_q;  // mul: multiplier shifting right; div: divisor magnitude
  logic [2*XLEN-1:0] p_q;  // mul: product accumulator; div: low half is partial remainder

  logic            word_in, illegal, accept, s1, s2, neg1, neg2;
  logic            div_zero, div_ovf, special, neg_in;
  logic [XLEN-1:0] ext1, ext2, mag1, mag2, most_neg, spec_raw, spec_res;
  logic [CW-1:0]   div_shift, w_last;

  always_comb begin
    word_in   = (XLEN == 64) && word_i;
    illegal   = word_in && (op_i inside {3'b001, 3'b010, 3'b011});
    accept    = start_i && !flush_i && !illegal;
    s1        = op_i inside {3'b001, 3'b010, 3'b100, 3'b110};
    s2        = op_i inside {3'b001, 3'b100, 3'b110};
    if (word_in) begin
      ext1     = s1 ? XLEN'($signed(op1_i[31:0])) : XLEN'(op1_i[31:0]);
      ext2     = s2 ? XLEN'($signed(op2_i[31:0])) : XLEN'(op2_i[31:0]);
      most_neg = XLEN'($signed(32'h8000_0000));
    end else begin
      ext1     = op1_i;
      ext2     = op2_i;
      most_neg = {1'b1, {(XLEN-1){1'b0}}};
    end
    neg1      = s1 && ext1[XLEN-1];
    neg2      = s2 && ext2[XLEN-1];
    mag1      = neg1 ? -ext1 : ext1;
    mag2      = neg2 ? -ext2 : ext2;
    div_zero  = op_i[2] && (ext2 == '0);
    div_ovf   = op_i[2] && !op_i[0] && (ext1 == most_neg) && (ext2 == '1);
    special   = div_zero || div_ovf;
    spec_raw  = div_zero ? (op_i[1] ? ext1 : '1) : (op_i[1] ? '0 : ext1);
    spec_res  = word_in ? XLEN'($signed(spec_raw[31:0])) : spec_raw;
    // MUL keeps only the low half, which is identical for signed and unsigned operands
    neg_in    = (op_i == OP_MUL) ? 1'b0 : (op_i[2] && op_i[1]) ? neg1 : (neg1 ^ neg2);
    // word dividends start at the top so the quotient lands in the low 32 bits after 32 steps
    div_shift = word_in ? CW'(XLEN - 32) : '0;
  end

  logic [XLEN:0]     r_sh;
  logic [XLEN-1:0]   r_sub;
  logic              r_ge;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   mul_res, div_raw, div_res, raw, fin_res;

  always_comb begin
    w_last  = word_q ? CW'(31) : CW'(XLEN - 1);
    r_sh    = {p_q[XLEN-1:0], a_q[XLEN-1]};
    r_ge    = r_sh >= {1'b0, b_q};
    r_sub   = r_sh[XLEN-1:0] - b_q;
    prod    = neg_q ? -p_q : p_q;
    mul_res = (op_q == OP_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    div_raw = op_q[1] ? p_q[XLEN-1:0] : a_q[XLEN-1:0];
    div_res = neg_q ? -div_raw : div_raw;
    raw     = op_q[2] ? div_res : mul_res;
    fin_res = word_q ? XLEN'($signed(raw[31:0])) : raw;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      count      <= '0;
      op_q       <= '0;
      word_q     <= 1'b0;
      neg_q      <= 1'b0;
      rd_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      p_q        <= '0;
      rd_wdata_o <= '0;
      rd_waddr_o <= '0;
      reg_wen_o  <= 1'b0;
    end else begin
      reg_wen_o <= 1'b0;
      if (flush_i) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (accept) begin
              op_q   <= op_i;
              word_q <= word_in;
              neg_q  <= neg_in;
              rd_q   <= rd_addr_i;
              count  <= '0;
              if (special) begin
                rd_wdata_o <= spec_res;
                rd_waddr_o <= rd_addr_i;
                reg_wen_o  <= (rd_addr_i != '0);
                state      <= DONE;
              end else begin
                b_q   <= mag2;
                p_q   <= '0;
                a_q   <= op_i[2] ? (2*XLEN)'(mag1 << div_shift) : (2*XLEN)'(mag1);
                state <= CALC;
              end
            end
          end
          CALC: begin
            count <= count + CW'(1);
            if (op_q[2]) begin
              p_q[XLEN-1:0] <= r_ge ? r_sub : r_sh[XLEN-1:0];
              a_q[XLEN-1:0] <= {a_q[XLEN-2:0], r_ge};
            end else begin
              p_q <= b_q[0] ? p_q + a_q : p_q;
              a_q <= a_q << 1;
              b_q <= b_q >> 1;
            end
            if (count == w_last) state <= FIN;
          end
          FIN: begin
            rd_wdata_o <= fin_res;
            rd_waddr_o <= rd_q;
            reg_wen_o  <= (rd_q != '0);
            state      <= DONE;
          end
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign busy_o      = (state != IDLE);
  assign hold_flag_o = !flush_i && ((state == IDLE && accept) || state == CALC || state == FIN);

endmodule

// File: tb/tb_ex_mdu.sv
// Directed plus random bench for ex_mdu (XLEN=64): scoreboard of expected writes, latency and hold checks.
module tb_ex_mdu;
  localparam int XLEN = 64;
  localparam int RD_W = 5;

  logic            clk;
  logic            rst;
  logic            start_i;
  logic [2:0]      op_i;
  logic            word_i;
  logic [XLEN-1:0] op1_i;
  logic [XLEN-1:0] op2_i;
  logic [RD_W-1:0] rd_addr_i;
  logic            flush_i;
  logic            busy_o;
  logic            hold_flag_o;
  logic [XLEN-1:0] rd_wdata_o;
  logic [RD_W-1:0] rd_waddr_o;
  logic            reg_wen_o;

  int pass_cnt  = 0;
  int fail_cnt  = 0;
  int total_cnt = 0;
  int wen_cnt   = 0;
  string cur_tag = "reset";
  logic [63:0] exp_q[$];
  logic [4:0]  exp_rd_q[$];
  logic [63:0] mon_exp;
  logic [4:0]  mon_rd;

  ex_mdu #(.XLEN(XLEN), .RD_W(RD_W)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .op_i(op_i), .word_i(word_i),
    .op1_i(op1_i), .op2_i(op2_i), .rd_addr_i(rd_addr_i), .flush_i(flush_i),
    .busy_o(busy_o), .hold_flag_o(hold_flag_o), .rd_wdata_o(rd_wdata_o),
    .rd_waddr_o(rd_waddr_o), .reg_wen_o(reg_wen_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] ref_mdu(input logic [2:0] op, input logic word,
                                          input logic [63:0] a, input logic [63:0] b);
    logic signed [127:0] sa, sb;
    logic [127:0]        ua, ub, p;
    logic signed [63:0]  a64, b64, q64;
    logic signed [31:0]  a32, b32;
    logic [31:0]         r32;
    logic [63:0]         r;
    r = '0;
    if (!word) begin
      a64 = a; b64 = b; sa = a64; sb = b64; ua = {64'd0, a}; ub = {64'd0, b};
      case (op)
        3'd0: begin p = ua * ub; r = p[63:0]; end
        3'd1: begin p = sa * sb; r = p[127:64]; end
        3'd2: begin p = sa * $signed(ub); r = p[127:64]; end
        3'd3: begin p = ua * ub; r = p[127:64]; end
        3'd4: if (b == 0) r = '1;
              else if (a == 64'h8000_0000_0000_0000 && b == '1) r = a;
              else begin q64 = a64 / b64; r = q64; end
        3'd5: r = (b == 0) ? '1 : a / b;
        3'd6: if (b == 0) r = a;
              else if (a == 64'h8000_0000_0000_0000 && b == '1) r = '0;
              else begin q64 = a64 % b64; r = q64; end
        default: r = (b == 0) ? a : a % b;
      endcase
    end else begin
      a32 = a[31:0]; b32 = b[31:0];
      case (op)
        3'd4: if (b32 == 0) r32 = '1;
              else if (a32 == 32'sh8000_0000 && b32 == -32'sd1) r32 = a32;
              else r32 = a32 / b32;
        3'd5: r32 = (b[31:0] == 0) ? '1 : a[31:0] / b[31:0];
        3'd6: if (b32 == 0) r32 = a32;
              else if (a32 == 32'sh8000_0000 && b32 == -32'sd1) r32 = '0;
              else r32 = a32 % b32;
        3'd7: r32 = (b[31:0] == 0) ? a[31:0] : a[31:0] % b[31:0];
        default: r32 = a[31:0] * b[31:0];
      endcase
      r = {{32{r32[31]}}, r32};
    end
    return r;
  endfunction

  function automatic bit is_special(input logic [2:0] op, input logic word,
                                    input logic [63:0] a, input logic [63:0] b);
    bit zero, ovf;
    zero = word ? (b[31:0] == 0) : (b == 0);
    ovf  = word ? (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF)
                : (a == 64'h8000_0000_0000_0000 && b == '1);
    return op[2] && (zero || (!op[0] && ovf));
  endfunction

  always @(negedge clk) begin
    if (rst && reg_wen_o) begin
      wen_cnt++;
      if (exp_q.size() == 0) begin
        check({cur_tag, "_unexpected_write"}, 64'(reg_wen_o), 64'd0);
      end else begin
        mon_exp = exp_q.pop_front();
        mon_rd  = exp_rd_q.pop_front();
        check({cur_tag, "_wdata"}, rd_wdata_o, mon_exp);
        check({cur_tag, "_waddr"}, 64'(rd_waddr_o), 64'(mon_rd));
      end
    end
  end

  task automatic do_op(input string tag, input logic [2:0] op, input logic word,
                       input logic [63:0] a, input logic [63:0] b, input logic [4:0] rd,
                       input logic [63:0] exp_val, input int exp_lat, input int pulse_k,
                       input int abort_k, input bit abort_rst, input bit no_wait);
    int first_wen;
    int hold_cnt;
    cur_tag = tag;
    if (!no_wait) begin
      @(posedge clk);
      #1;
    end
    start_i = 1'b1; op_i = op; word_i = word; op1_i = a; op2_i = b; rd_addr_i = rd;
    if (rd != 0 && abort_k == 0) begin
      exp_q.push_back(exp_val);
      exp_rd_q.push_back(rd);
    end
    first_wen = 0;
    hold_cnt  = 0;
    @(negedge clk);
    check({tag, "_hold_c0"}, 64'(hold_flag_o), 64'd1);
    for (int k = 1; k <= exp_lat + 3; k++) begin
      @(posedge clk);
      #1;
      start_i = (k == pulse_k);
      if (k == pulse_k) op1_i = ~a;
      if (k == abort_k) begin
        if (abort_rst) rst = 1'b0;
        else flush_i = 1'b1;
      end
      @(negedge clk);
      if (hold_flag_o) hold_cnt++;
      if (reg_wen_o && first_wen == 0) first_wen = k;
      if (k == abort_k) begin
        if (!abort_rst) check({tag, "_hold_flush"}, 64'(hold_flag_o), 64'd0);
        return;
      end
      if (k == exp_lat) check({tag, "_busy_done"}, 64'(busy_o), 64'd1);
      if (k == exp_lat + 1) check({tag, "_busy_idle"}, 64'(busy_o), 64'd0);
    end
    check({tag, "_wen_cycle"}, 64'(first_wen), (rd != 0) ? 64'(exp_lat) : 64'd0);
    check({tag, "_hold_cycles"}, 64'(hold_cnt), 64'(exp_lat - 1));
  endtask

  initial begin
    int w0;
    logic [2:0]  rop;
    logic        rw;
    logic [63:0] ra, rb;
    logic [4:0]  rrd;
    rst = 1'b0; start_i = 1'b0; op_i = '0; word_i = 1'b0;
    op1_i = '0; op2_i = '0; rd_addr_i = '0; flush_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 64'(busy_o), 64'd0);
    check("rst_hold", 64'(hold_flag_o), 64'd0);
    check("rst_wen", 64'(reg_wen_o), 64'd0);
    check("rst_wdata", rd_wdata_o, 64'd0);
    check("rst_waddr", 64'(rd_waddr_o), 64'd0);
    rst = 1'b1;

    do_op("mul", 3'b000, 0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 5'd1, 64'hFFFF_FFFF_FFFF_FFEB, 66, 0, 0, 0, 0);
    do_op("mulhu", 3'b011, 0, '1, '1, 5'd2, 64'hFFFF_FFFF_FFFF_FFFE, 66, 0, 0, 0, 0);
    do_op("mulh", 3'b001, 0, '1, '1, 5'd3, 64'd0, 66, 0, 0, 0, 0);
    do_op("div_zero", 3'b100, 0, 64'd20, 64'd0, 5'd4, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0, 0, 0, 0);
    do_op("remu_zero", 3'b111, 0, 64'd20, 64'd0, 5'd5, 64'd20, 1, 0, 0, 0, 0);
    do_op("div_ovf", 3'b100, 0, 64'h8000_0000_0000_0000, '1, 5'd6, 64'h8000_0000_0000_0000, 1, 0, 0, 0, 0);
    do_op("rem_ovf", 3'b110, 0, 64'h8000_0000_0000_0000, '1, 5'd7, 64'd0, 1, 0, 0, 0, 0);
    do_op("divw", 3'b100, 1, 64'h0000_0001_FFFF_FFF9, 64'd2, 5'd8, 64'hFFFF_FFFF_FFFF_FFFD, 34, 0, 0, 0, 0);
    do_op("remw", 3'b110, 1, 64'h0000_0001_FFFF_FFF9, 64'd2, 5'd9, 64'hFFFF_FFFF_FFFF_FFFF, 34, 0, 0, 0, 0);
    do_op("divu_rd0", 3'b101, 0, 64'd100, 64'd7, 5'd0, 64'd0, 66, 0, 0, 0, 0);

    w0 = wen_cnt;
    do_op("divu_flush", 3'b101, 0, 64'd1000, 64'd3, 5'd3, 64'd0, 66, 0, 10, 0, 0);
    @(posedge clk);
    #1;
    flush_i = 1'b0;
    check("flush_busy_c11", 64'(busy_o), 64'd0);
    check("flush_no_write", 64'(wen_cnt), 64'(w0));
    do_op("divu_after_flush", 3'b101, 0, 64'd1000, 64'd3, 5'd4, 64'd333, 66, 0, 0, 0, 1);

    do_op("mulhu_pulse", 3'b011, 0, 64'h1234_5678_9ABC_DEF0, 64'h0000_0001_0000_0000, 5'd6,
          64'h0000_0000_1234_5678, 66, 5, 0, 0, 0);

    w0 = wen_cnt;
    do_op("mul_rst", 3'b000, 0, 64'd5, 64'd6, 5'd7, 64'd0, 66, 0, 20, 1, 0);
    @(posedge clk);
    #1;
    check("midrst_busy", 64'(busy_o), 64'd0);
    check("midrst_hold", 64'(hold_flag_o), 64'd0);
    check("midrst_wen", 64'(reg_wen_o), 64'd0);
    check("midrst_wdata", rd_wdata_o, 64'd0);
    check("midrst_waddr", 64'(rd_waddr_o), 64'd0);
    rst = 1'b1;
    check("midrst_no_write", 64'(wen_cnt), 64'(w0));

    cur_tag = "mulhw_illegal";
    @(posedge clk);
    #1;
    start_i = 1'b1; op_i = 3'b001; word_i = 1'b1; op1_i = 64'd3; op2_i = 64'd4; rd_addr_i = 5'd9;
    @(negedge clk);
    check("mulhw_hold", 64'(hold_flag_o), 64'd0);
    @(posedge clk);
    #1;
    start_i = 1'b0;
    check("mulhw_busy", 64'(busy_o), 64'd0);

    for (int i = 0; i < 10; i++) begin
      rop = 3'($urandom_range(0, 7));
      rw  = (rop == 3'd0 || rop[2]) ? 1'($urandom_range(0, 1)) : 1'b0;
      ra  = {$urandom, $urandom};
      rb  = {$urandom, $urandom};
      if (i % 3 == 0) rb = 64'($urandom_range(1, 9));
      if (i == 4) rb = 64'd0;
      rrd = 5'($urandom_range(1, 31));
      do_op($sformatf("rand%0d_op%0d_w%0d", i, rop, rw), rop, rw, ra, rb, rrd, ref_mdu(rop, rw, ra, rb),
            is_special(rop, rw, ra, rb) ? 1 : (rw ? 34 : 66), 0, 0, 0, 0);
    end

    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/ex_mdu.md
Name: ex_mdu

Overview:
Parametrised multi-cycle multiply/divide unit for the execute stage. It implements the RV M-extension (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU) and the RV64 word variants. It runs beside the single-cycle ALU: it raises hold_flag_o to ctrl while iterating, then writes rd through the same regs write port as the ALU. It uses an iterative 1-bit-per-cycle shift-add multiplier and a restoring divider, with a fast path for divide special cases.

Parameters:
XLEN, 64, datapath width (32 or 64)
RD_W, 5, register address width

Ports:
clk  in  1  system clock
rst  in  1  reset; synchronous, active-low
start_i  in  1  id_ex presents an M-extension op this cycle
op_i  in  3  func3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
word_i  in  1  *W variant (OP-32); ignored when XLEN=32
op1_i  in  XLEN  rs1 value
op2_i  in  XLEN  rs2 value
rd_addr_i  in  RD_W  destination register
flush_i  in  1  ctrl jump/flush; aborts the current op
busy_o  out  1  state != IDLE
hold_flag_o  out  1  stall request to ctrl
rd_wdata_o  out  XLEN  result
rd_waddr_o  out  RD_W  destination address
reg_wen_o  out  1  one-cycle write strobe

Behaviour:
- Reset (rst==0 at a clk edge): state=IDLE, count=0, all registered outputs 0. Reset mid-operation discards the op with no write.
- States:
  - IDLE: start_i accepted only here, and only if flush_i==0. Operands, op, word and rd are latched. The FSM goes to DONE if a special case applies, else to CALC with count=0.
  - CALC: one iteration per cycle; count++. When count==W-1, the FSM goes to FIN. W=32 if word_i, else XLEN.
  - FIN: applies sign correction and the word sign-extension, registers the result, and goes to DONE.
  - DONE: rd_wdata_o/rd_waddr_o valid; reg_wen_o=1 unless rd==0. Next state is IDLE.
- Latency: the start cycle is cycle 0.
  - Normal op: CALC cycles 1..W, FIN cycle W+1, reg_wen_o in cycle W+2.
  - Special case: reg_wen_o in cycle 1.
- hold_flag_o = (state==IDLE & start_i & ~flush_i) | state==CALC | state==FIN. It is combinational, so the pipeline stalls in the start cycle. It is low in DONE so the pipeline advances as the write lands.
- start_i while busy: ignored, with no effect on the op in flight.
- flush_i in any state: the FSM goes to IDLE at the next edge. No write occurs, and hold_flag_o drops in that same cycle. flush_i outranks start_i.
- Signed handling: operands are converted to magnitudes, unsigned iteration runs, and the result is negated when required.
  - MULHSU: op1 is signed, op2 is unsigned.
  - Remainder sign follows the dividend.
- MUL returns the low XLEN bits of the product. MULH/MULHSU/MULHU return the high XLEN bits of the 2*XLEN product.
- Word variants:
  - Operands use bits [31:0]; signed ops sign-extend them and unsigned ops zero-extend them.
  - The 32-bit result is sign-extended to XLEN, including DIVUW/REMUW.
  - word_i with op 001/010/011 is illegal: start is ignored, with no hold and no write.
- Special cases (no CALC, width = W):
  - Divide by zero: quotient = all ones; remainder = dividend.
  - Signed overflow (dividend = most-negative, divisor = -1): quotient = dividend; remainder = 0.
- Writes to rd==0 perform the full timing but keep reg_wen_o=0.

Test Plan:
1. XLEN=64, MUL op1=7, op2=0xFFFF_FFFF_FFFF_FFFD -> hold_flag_o high in cycles 0..65; reg_wen_o exactly in cycle 66; rd_wdata_o=0xFFFF_FFFF_FFFF_FFEB.
2. MULHU with both operands 0xFFFF_FFFF_FFFF_FFFF -> rd_wdata_o=0xFFFF_FFFF_FFFF_FFFE. MULH with the same operands -> 0.
3. DIV op1=20, op2=0 -> reg_wen_o in cycle 1, rd_wdata_o=0xFFFF_FFFF_FFFF_FFFF. REMU with the same operands -> 20, also in cycle 1.
4. DIV op1=0x8000_0000_0000_0000, op2=0xFFFF_FFFF_FFFF_FFFF -> rd_wdata_o=0x8000_0000_0000_0000. REM with the same operands -> 0. Latency 1 for both.
5. DIVW op1=0x0000_0001_FFFF_FFF9, op2=2 -> rd_wdata_o=0xFFFF_FFFF_FFFF_FFFD with reg_wen_o in cycle 34. REMW with the same operands -> 0xFFFF_FFFF_FFFF_FFFF.
6. Aborts and ignored starts:
   - DIVU started, flush_i pulsed in cycle 10 -> no reg_wen_o; busy_o=0 from cycle 11; a new start in cycle 11 completes normally.
   - start_i pulsed in cycle 5 of a busy op -> ignored.
   - rst=0 in cycle 20 -> all outputs 0; no write.
